core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle sequencer that replaces free-running PC advance in the RV32 core with a FETCH/EXEC/WB state machine. It sits between the instruction memory, the PC register, the decoder's write enable and the register file. It handshakes with a variable-latency instruction memory and holds the fetched instruction stable for the decoder, ALU and register file. It gates PC advance and register write-back to a single cycle per instruction, counts retired instructions and halts on EBREAK.

## Interface
- `XLEN`, 32: instruction and data width.
- `CNT_W`, 16: width of the retired-instruction counter.
- `TIMEOUT`, 8: fetch watchdog limit in cycles; only used when `SEQ_TIMEOUT_EN` is defined; legal range 1..255.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `run`  in  1: execution enable; level sampled on the rising edge.
- `imem_req`  out  1: fetch request to instruction memory.
- `imem_ready`  in  1: instruction memory data valid this cycle.
- `imem_rdata`  in  XLEN: instruction word from memory.
- `inst`  out  XLEN: instruction register output, driven to the decoder and register file.
- `ctrl_regwen`  in  1: write enable from the decoder.
- `reg_we`  out  1: gated register-file write enable.
- `pc_en`  out  1: one-cycle PC advance strobe.
- `state`  out  3: current state, IDLE=0, FETCH=1, EXEC=2, WB=3, HALT=4.
- `halted`  out  1: high while in HALT.
- `fetch_err`  out  1: fetch watchdog fired.
- `retired_cnt`  out  CNT_W: count of instructions completed through WB.

## Operation
- Reset values:
  - state=IDLE.
  - `inst`=32'h0000_0013 (NOP).
  - `retired_cnt`=0; `fetch_err`=0.
  - `imem_req`, `reg_we`, `pc_en`, `halted` all 0.
- All control outputs are Moore (decoded from registered state only). `reg_we` is additionally ANDed with `ctrl_regwen`.
- IDLE: when `run`=1, go to FETCH; otherwise stay.
- FETCH:
  - `imem_req`=1.
  - On `imem_ready`=1, capture `imem_rdata` into `inst` and go to EXEC; otherwise stay.
  - `run` is ignored; a started fetch always completes.
- EXEC: single settle cycle for the ALU; no strobes.
  - If `inst`==32'h0010_0073 (EBREAK), go to HALT.
  - Otherwise go to WB.
- WB:
  - `reg_we`=`ctrl_regwen`, `pc_en`=1.
  - `retired_cnt` increments, wrapping modulo 2^CNT_W.
  - If `run`=1, go to FETCH; otherwise go to IDLE.
- HALT:
  - `halted`=1.
  - EBREAK does not retire: no `pc_en`, no `reg_we`, no count.
  - Stay while `run`=1; go to IDLE when `run`=0, which also clears `fetch_err`.
- `inst` changes only on the FETCH capture edge and on reset.
- Encodings 5..7 are unreachable; if entered, the next state is IDLE.

## Timing
- Minimum instruction period is 3 cycles (FETCH with same-cycle ready, EXEC, WB). Each extra cycle of `imem_ready` latency adds one FETCH cycle.
- `run` rising at edge N: `imem_req` is high in cycle N+1.
- Back-to-back instructions: `pc_en` pulses once every 3 cycles; never two consecutive cycles.
- `run` dropping during FETCH or EXEC: the current instruction completes through WB, then the block enters IDLE.
- `imem_ready` outside FETCH is ignored.
- Asynchronous reset mid-operation: all outputs take their reset values immediately. Any pending fetch is abandoned, no WB occurs, and `retired_cnt` is cleared.
- Counter wrap: at `retired_cnt`=2^CNT_W−1, the next WB yields 0.

## Configuration
- `SEQ_TIMEOUT_EN` defined: a stall counter runs during FETCH, counting consecutive cycles with `imem_ready`=0.
  - On reaching `TIMEOUT` stalled cycles, the next state is HALT and `fetch_err` is set (sticky until HALT→IDLE or reset).
  - `imem_ready`=1 in the same cycle as the limit takes priority: normal capture, no error.
  - The counter clears on entry to FETCH.
- Not defined: no stall counter; FETCH waits indefinitely; `fetch_err` is tied to 0.

## Test plan
- Reset: `rst_n`=0 → `state`=0, `inst`=32'h0000_0013, `retired_cnt`=0, all strobes 0.
- Zero-latency stream: `run`=1, `imem_ready` held 1, 4 ADD words → `pc_en` exactly every 3rd cycle, `reg_we`=1 on WB, `retired_cnt`=4.
- Wait states: `imem_ready` after 2 stall cycles, `ctrl_regwen`=0 → instruction takes 5 cycles, `reg_we` stays 0, `pc_en` pulses once.
- EBREAK: fetch 32'h0010_0073 → HALT after EXEC, `halted`=1, no `pc_en`, count unchanged; `run`=0 → IDLE.
- Reset mid-FETCH: assert `rst_n`=0 while `imem_req`=1 → outputs reset the same cycle, no WB, later `imem_ready` is ignored.
- Watchdog (`SEQ_TIMEOUT_EN`, `TIMEOUT`=4): `imem_ready` never asserted → HALT with `fetch_err`=1 after 4 stall cycles. Repeat with ready on stall cycle 4 → normal EXEC, `fetch_err`=0.

Source files
------------

// File: rtl/core_sequencer.sv
// core_sequencer: FETCH/EXEC/WB control sequencer for the RV32 core.
// Handshakes with a variable-latency instruction memory, holds the fetched
// word for decode, and gates PC advance and register write-back to one
// cycle per instruction. Halts on EBREAK.
// Optional fetch watchdog: define SEQ_TIMEOUT_EN to enable it.
//
// Handshake: imem_req is high for every FETCH cycle; a word is accepted on
// the rising edge where imem_req=1 and imem_ready=1. imem_ready in any
// other state has no effect.
module core_sequencer #(
  parameter int XLEN    = 32,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  inst,
  input  logic             ctrl_regwen,
  output logic             reg_we,
  output logic             pc_en,
  output logic [2:0]       state,
  output logic             halted,
  output logic             fetch_err,
  output logic [CNT_W-1:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [XLEN-1:0] NOP_WORD    = XLEN'(32'h0000_0013);
  localparam logic [XLEN-1:0] EBREAK_WORD = XLEN'(32'h0010_0073);

  state_t cur_state;
  state_t nxt_state;
  logic   timeout_hit;

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] stall_cnt;

  // Count consecutive stalled FETCH cycles; zero outside FETCH so every
  // fetch starts from a clean count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (cur_state != S_FETCH) begin
      stall_cnt <= '0;
    end else if (!imem_ready) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end

  // The current cycle is the TIMEOUT-th stall; a ready in this cycle wins.
  assign timeout_hit = (cur_state == S_FETCH) && !imem_ready &&
                       (stall_cnt == 8'(TIMEOUT - 1));

  // Sticky error flag, cleared only when leaving HALT or on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_err <= 1'b0;
    end else if (timeout_hit) begin
      fetch_err <= 1'b1;
    end else if (cur_state == S_HALT && !run) begin
      fetch_err <= 1'b0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= S_IDLE;
    end else begin
      cur_state <= nxt_state;
    end
  end

  // Next-state logic; unused encodings fall back to IDLE.
  always_comb begin
    nxt_state = S_IDLE;
    case (cur_state)
      S_IDLE:  nxt_state = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (imem_ready)       nxt_state = S_EXEC;
        else if (timeout_hit) nxt_state = S_HALT;
        else                  nxt_state = S_FETCH;
      end
      S_EXEC:  nxt_state = (inst == EBREAK_WORD) ? S_HALT : S_WB;
      S_WB:    nxt_state = run ? S_FETCH : S_IDLE;
      S_HALT:  nxt_state = run ? S_HALT : S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Instruction register: loads only on the accepting FETCH edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst <= NOP_WORD;
    end else if (cur_state == S_FETCH && imem_ready) begin
      inst <= imem_rdata;
    end
  end

  // Retired counter: one increment per WB cycle, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt <= '0;
    end else if (cur_state == S_WB) begin
      retired_cnt <= retired_cnt + 1'b1;
    end
  end

  // Moore outputs decoded from the registered state.
  assign imem_req = (cur_state == S_FETCH);
  assign pc_en    = (cur_state == S_WB);
  assign reg_we   = (cur_state == S_WB) && ctrl_regwen;
  assign halted   = (cur_state == S_HALT);
  assign state    = cur_state;

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer: directed bench for core_sequencer with a memory
// responder, a retire scoreboard and a final report.
// Watchdog vectors run only when SEQ_TIMEOUT_EN is defined.
module tb_core_sequencer;

  localparam int XLEN    = 32;
  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int EW      = XLEN + 1 + CNT_W;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;
  localparam logic [31:0] EBREAK_W = 32'h0010_0073;

  logic             clk;
  logic             rst_n;
  logic             run;
  logic             imem_req;
  logic             imem_ready;
  logic [XLEN-1:0]  imem_rdata;
  logic [XLEN-1:0]  inst;
  logic             ctrl_regwen;
  logic             reg_we;
  logic             pc_en;
  logic [2:0]       state;
  logic             halted;
  logic             fetch_err;
  logic [CNT_W-1:0] retired_cnt;

  core_sequencer #(.XLEN(XLEN), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst(inst), .ctrl_regwen(ctrl_regwen), .reg_we(reg_we), .pc_en(pc_en),
    .state(state), .halted(halted), .fetch_err(fetch_err),
    .retired_cnt(retired_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // ---------------- shared state ----------------
  int errors = 0;
  int checks = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [31:0]      prog[64];
  int  pc = 0;
  int  lat = 0;
  int  wait_cnt = 0;
  bit  hold_ready = 0;
  bit  ready_force = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- memory responder (driver side) ----------------
  // Acts as PC register and instruction memory; pushes the expected retire
  // record whenever it offers a word the sequencer will accept.
  always begin
    @(posedge clk);
    #1;
    if (pc_en) pc = pc + 1;
    if (imem_req) begin
      imem_ready = hold_ready || (wait_cnt >= lat);
      wait_cnt   = wait_cnt + 1;
    end else begin
      wait_cnt   = 0;
      imem_ready = hold_ready || ready_force;
    end
    imem_rdata = prog[pc];
    if (imem_req && imem_ready && imem_rdata != EBREAK_W) begin
      exp_q.push_back({imem_rdata, ctrl_regwen, exp_cnt});
      exp_cnt = exp_cnt + 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] exp_v;
    logic [EW-1:0] got_v;
    if (rst_n && pc_en) begin
      checks++;
      got_v = {inst, reg_we, retired_cnt};
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL retire_unexpected: got inst=%h we=%b cnt=%0d with nothing expected",
                 inst, reg_we, retired_cnt);
      end else begin
        exp_v = exp_q.pop_front();
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL retire: got inst=%h we=%b cnt=%0d expected inst=%h we=%b cnt=%0d",
                   got_v[EW-1 -: XLEN], got_v[CNT_W], got_v[CNT_W-1:0],
                   exp_v[EW-1 -: XLEN], exp_v[CNT_W], exp_v[CNT_W-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pc(output bit ok);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (pc_en) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic wait_state(input logic [2:0] s, output bit ok);
    ok = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (state == s) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Back-to-back stream of n (>=2) instructions, then back to IDLE.
  task automatic stream(input int n);
    int t_prev;
    bit ok;
    t_prev = 0;
    @(posedge clk); #2 run = 1;
    for (int i = 0; i < n; i++) begin
      wait_pc(ok);
      chk("stream_pc_en_seen", 32'(ok), 32'd1);
      if (!ok) begin
        run = 0;
        return;
      end
      if (i > 0) chk("pc_en_period", 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
      if (i == n - 2) begin
        @(posedge clk); #2 run = 0;
      end
    end
    @(negedge clk);
    chk("stream_idle", 32'(state), 32'd0);
  endtask

  // Single instruction; exp_cycles counts FETCH through WB inclusive.
  task automatic run_one(input int exp_cycles);
    int t0;
    bit ok;
    @(posedge clk); #2 run = 1;
    @(posedge clk); #2 run = 0;
    t0 = cyc;
    chk("one_fetch_state", 32'(state), 32'd1);
    wait_pc(ok);
    chk("one_pc_en_seen", 32'(ok), 32'd1);
    if (ok) chk("inst_period", 32'(cyc - t0 + 1), 32'(exp_cycles));
    @(negedge clk);
    chk("one_idle", 32'(state), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int t0;
    rst_n = 0; run = 0; ctrl_regwen = 0;
    imem_ready = 0; imem_rdata = '0;
    for (int i = 0; i < 64; i++) prog[i] = 32'h0020_8033 | (32'(i) << 7);

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_inst", inst, NOP_W);
    chk("rst_cnt", 32'(retired_cnt), 32'd0);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_pc_en", 32'(pc_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);
    @(posedge clk); #2 rst_n = 1;

    // Zero-latency stream of 4 ADDs, ready held high throughout
    ctrl_regwen = 1; hold_ready = 1;
    stream(4);
    chk("stream_cnt", 32'(retired_cnt), 32'd4);

    // Two wait states, write-back disabled: 5-cycle instruction
    hold_ready = 0; lat = 2; ctrl_regwen = 0;
    run_one(5);
    chk("wait_cnt", 32'(retired_cnt), 32'd5);

    // EBREAK: halts after EXEC, does not retire
    lat = 0; ctrl_regwen = 1;
    prog[pc] = EBREAK_W;
    @(posedge clk); #2 run = 1;
    wait_state(3'd2, ok);
    chk("ebreak_exec_seen", 32'(ok), 32'd1);
    chk("ebreak_inst", inst, EBREAK_W);
    @(negedge clk);
    chk("ebreak_halt_state", 32'(state), 32'd4);
    chk("ebreak_halted", 32'(halted), 32'd1);
    repeat (3) @(negedge clk);
    chk("ebreak_stays", 32'(state), 32'd4);
    chk("ebreak_cnt", 32'(retired_cnt), 32'd5);
    @(posedge clk); #2 run = 0;
    @(posedge clk);
    @(negedge clk);
    chk("ebreak_to_idle", 32'(state), 32'd0);
    chk("ebreak_unhalted", 32'(halted), 32'd0);
    prog[pc] = 32'h0041_8233;

    // Reset while a fetch is outstanding
    lat = 1000;
    @(posedge clk); #2 run = 1;
    wait_state(3'd1, ok);
    chk("rstf_fetch_seen", 32'(ok), 32'd1);
    chk("rstf_req_high", 32'(imem_req), 32'd1);
    #1 rst_n = 0;
    run = 0;
    #1;
    chk("rstf_state", 32'(state), 32'd0);
    chk("rstf_req", 32'(imem_req), 32'd0);
    chk("rstf_inst", inst, NOP_W);
    chk("rstf_cnt", 32'(retired_cnt), 32'd0);
    exp_cnt = '0;
    @(posedge clk); #2 rst_n = 1; ready_force = 1;
    repeat (4) @(negedge clk);
    chk("rstf_ignore_state", 32'(state), 32'd0);
    chk("rstf_ignore_inst", inst, NOP_W);
    chk("rstf_ignore_cnt", 32'(retired_cnt), 32'd0);
    ready_force = 0; lat = 0;

    // Counter wrap: 17 retires on a 4-bit counter
    hold_ready = 1; ctrl_regwen = 1;
    stream(17);
    chk("wrap_cnt", 32'(retired_cnt), 32'd1);
    hold_ready = 0;

`ifdef SEQ_TIMEOUT_EN
    // Watchdog: memory never answers
    lat = 1000;
    @(posedge clk); #2 run = 1;
    @(posedge clk); #2;
    t0 = cyc;
    wait_state(3'd4, ok);
    chk("wd_halt_seen", 32'(ok), 32'd1);
    chk("wd_stall_cycles", 32'(cyc - t0), 32'd4);
    chk("wd_fetch_err", 32'(fetch_err), 32'd1);
    chk("wd_halted", 32'(halted), 32'd1);
    @(posedge clk); #2 run = 0;
    @(posedge clk);
    @(negedge clk);
    chk("wd_idle", 32'(state), 32'd0);
    chk("wd_err_cleared", 32'(fetch_err), 32'd0);
    // Ready on the fourth FETCH cycle wins over the limit
    lat = 3;
    run_one(6);
    chk("wd_no_err", 32'(fetch_err), 32'd0);
    lat = 0;
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
